// File: rtl/hilo_mdu_ctrl_pkg.sv
// hilo_mdu_ctrl_pkg: op codes, FSM states and shared helpers for the HI/LO multiply/divide sequencer
package hilo_mdu_ctrl_pkg;
  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_RSVD  = 3'b111
  } mdu_op_e;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;
  localparam int MDU_ITER = 32;
  // Two's-complement magnitude when the operand is treated as signed; 0x8000_0000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction
endpackage

// File: rtl/hilo_mdu_ctrl_mdu_iter_core.sv
// mdu_iter_core: unsigned 64-bit shift-add multiply / restoring divide datapath, one step per enable
module mdu_iter_core #(
  parameter int DATA_W   = 32,
  parameter int MUL_FAST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic              is_div,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [DATA_W:0]   add_sum, shl, sub_diff;
  // hi is the accumulator/partial remainder, lo holds the multiplier/dividend and collects product or quotient bits
  always_comb begin
    add_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shl      = {hi_q, lo_q[DATA_W-1]};
    sub_diff = shl - {1'b0, b_q};
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    if (load) begin
      hi_d = '0;
      lo_d = a;
      b_d  = b;
    end else if (en) begin
      if (is_div) begin
        hi_d = sub_diff[DATA_W] ? shl[DATA_W-1:0] : sub_diff[DATA_W-1:0];
        lo_d = {lo_q[DATA_W-2:0], ~sub_diff[DATA_W]};
      end else if (MUL_FAST != 0) begin
        {hi_d, lo_d} = {{DATA_W{1'b0}}, lo_q} * {{DATA_W{1'b0}}, b_q};
      end else begin
        {hi_d, lo_d} = {add_sum, lo_q[DATA_W-1:1]};
      end
    end
  end
  // datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
      b_q  <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      b_q  <= b_d;
    end
  end
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: rtl/hilo_mdu_ctrl.sv
// hilo_mdu_ctrl: multi-cycle MULT/DIV sequencer owning all HI/LO register writes
module hilo_mdu_ctrl
  import hilo_mdu_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MUL_FAST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rt,
  input  logic              flush,
  output logic              stall,
  output logic              busy,
  output logic              hi_we,
  output logic              lo_we,
  output logic [DATA_W-1:0] hi_i,
  output logic [DATA_W-1:0] lo_i
);
  mdu_state_e        state_q, state_d;
  logic [4:0]        count_q, count_d;
  logic              div_q, div_d, neg_q, neg_d, negr_q, negr_d, dz_q, dz_d;
  logic [DATA_W-1:0] rs_q, rs_d;
  logic              live, issue_md, mthi, mtlo, signed_op, div_op, wr_done;
  logic [DATA_W-1:0] core_hi, core_lo, quo, rem;
  logic [2*DATA_W-1:0] prod, res;
  // decode the EX-stage request; flush masks everything and start only matters in IDLE
  always_comb begin
    live      = start && !flush && state_q == ST_IDLE;
    signed_op = op == OP_MULT || op == OP_DIV;
    div_op    = op == OP_DIV || op == OP_DIVU;
    issue_md  = live && (op == OP_MULT || op == OP_MULTU || div_op);
    mthi      = live && op == OP_MTHI;
    mtlo      = live && op == OP_MTLO;
  end
  // next-state, iteration count and latched sign/corner-case flags
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    div_d   = div_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    rs_d    = rs_q;
    if (flush) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (issue_md) begin
      state_d = ST_BUSY;
      count_d = '0;
      div_d   = div_op;
      neg_d   = signed_op && (rs[DATA_W-1] ^ rt[DATA_W-1]);
      negr_d  = signed_op && rs[DATA_W-1];
      dz_d    = div_op && rt == '0;
      rs_d    = rs;
    end else if (state_q == ST_BUSY) begin
      count_d = count_q + 5'd1;
      if (count_q == 5'(MDU_ITER - 1) || (MUL_FAST != 0 && !div_q)) begin
        state_d = ST_DONE;
        count_d = '0;
      end
    end else if (state_q == ST_DONE) begin
      state_d = ST_IDLE;
    end
  end
  // FSM and control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      rs_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      rs_q    <= rs_d;
    end
  end
  mdu_iter_core #(.DATA_W(DATA_W), .MUL_FAST(MUL_FAST)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (issue_md),
    .en     (state_q == ST_BUSY),
    .is_div (div_q),
    .a      (mag(rs, signed_op)),
    .b      (mag(rt, signed_op)),
    .hi     (core_hi),
    .lo     (core_lo)
  );
  // restore signs on the unsigned core result; divide-by-zero returns all-ones quotient and the raw dividend
  always_comb begin
    prod = {core_hi, core_lo};
    quo  = neg_q ? -core_lo : core_lo;
    rem  = negr_q ? -core_hi : core_hi;
    res  = dz_q ? {rs_q, {DATA_W{1'b1}}} : div_q ? {rem, quo} : neg_q ? -prod : prod;
  end
  // write port and pipeline handshake
  always_comb begin
    wr_done = state_q == ST_DONE && !flush;
    stall   = issue_md || (state_q == ST_BUSY && !flush);
    busy    = state_q != ST_IDLE;
    hi_we   = mthi || wr_done;
    lo_we   = mtlo || wr_done;
    hi_i    = mthi ? rs : wr_done ? res[2*DATA_W-1:DATA_W] : '0;
    lo_i    = mtlo ? rs : wr_done ? res[DATA_W-1:0] : '0;
  end
endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// tb_hilo_mdu_ctrl: scoreboard bench for the HI/LO multiply/divide sequencer
module tb_hilo_mdu_ctrl;
  localparam logic [2:0] NOP = 3'b000, MULT = 3'b001, MULTU = 3'b010, DIV = 3'b011,
                         DIVU = 3'b100, MTHI = 3'b101, MTLO = 3'b110, RSVD = 3'b111;
  logic clk = 0, rst = 1, start = 0, flush = 0;
  logic [2:0] op = 0;
  logic [31:0] rs = 0, rt = 0;
  logic stall, busy, hi_we, lo_we;
  logic [31:0] hi_i, lo_i;
  int errors = 0, checks = 0;
  logic [63:0] sb[$];

  hilo_mdu_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs(rs), .rt(rt), .flush(flush),
    .stall(stall), .busy(busy), .hi_we(hi_we), .lo_we(lo_we), .hi_i(hi_i), .lo_i(lo_i)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_, q, r;
    logic [63:0] qv, rv;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    if (o == MULT) return 64'(sa * sb_);
    if (o == MULTU) return {32'b0, a} * {32'b0, b};
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (o == DIV) begin
      q = sa / sb_;
      r = sa % sb_;
      qv = q;
      rv = r;
      return {rv[31:0], qv[31:0]};
    end
    return {a % b, a / b};
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp_v);
    int stalls = 0;
    bit seen = 0;
    logic [63:0] e;
    sb.push_back(exp_v);
    for (int c = 0; c < 60 && !seen; c++) begin
      @(posedge clk); #1;
      start = (c == 0);
      op = o; rs = a; rt = b;
      @(negedge clk);
      if (hi_we || lo_we) begin
        seen = 1;
        e = sb.pop_front();
        checks++;
        if ({hi_i, lo_i} !== e || !(hi_we && lo_we) || stall !== 1'b0) begin
          errors++;
          $display("FAIL op%0d %h/%h result: got hi=%h lo=%h we=%b%b stall=%b, want %h", o, a, b, hi_i, lo_i, hi_we, lo_we, stall, e);
        end
        checks++;
        if (stalls != 33 || c != 33) begin
          errors++;
          $display("FAIL op%0d latency: got stalls=%0d write_cycle=%0d, want 33/33", o, stalls, c);
        end
      end else if (stall) stalls++;
    end
    if (!seen) begin
      checks++; errors++;
      void'(sb.pop_front());
      $display("FAIL op%0d timeout: got no write pulse, want one at c33", o);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({stall, busy, hi_we, lo_we} !== 4'b0 || hi_i !== 0 || lo_i !== 0) begin
      errors++;
      $display("FAIL reset outputs: got stall=%b busy=%b we=%b%b hi=%h lo=%h, want all 0", stall, busy, hi_we, lo_we, hi_i, lo_i);
    end
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL post_reset idle: got busy=%b stall=%b, want 0 0", busy, stall);
    end
  endtask

  task automatic test_mul;
    do_op(MULT, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    do_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
    do_op(MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      do_op(i[0] ? MULTU : MULT, a, b, model(i[0] ? MULTU : MULT, a, b));
    end
  endtask

  task automatic test_div;
    do_op(DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_op(DIVU, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF});
    do_op(DIV, 32'hFFFF_FF00, 32'd0, {32'hFFFF_FF00, 32'hFFFF_FFFF});
    do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
    do_op(DIVU, 32'hFFFF_FFFF, 32'h8000_0001, {32'h7FFF_FFFE, 32'h1});
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom >> (i * 8);
      do_op(i[0] ? DIVU : DIV, a, b, model(i[0] ? DIVU : DIV, a, b));
    end
  endtask

  task automatic test_move;
    @(posedge clk); #1;
    start = 1; op = MTHI; rs = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (hi_we !== 1'b1 || hi_i !== 32'h1234_5678 || lo_we !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL mthi: got hi_we=%b hi_i=%h lo_we=%b stall=%b, want 1 12345678 0 0", hi_we, hi_i, lo_we, stall);
    end
    @(posedge clk); #1;
    op = MTLO; rs = 32'hCAFE_F00D;
    @(negedge clk);
    checks++;
    if (lo_we !== 1'b1 || lo_i !== 32'hCAFE_F00D || hi_we !== 1'b0 || stall !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mtlo: got lo_we=%b lo_i=%h hi_we=%b stall=%b busy=%b, want 1 cafef00d 0 0 0", lo_we, lo_i, hi_we, stall, busy);
    end
    @(posedge clk); #1;
    op = MTHI; flush = 1;
    @(negedge clk);
    checks++;
    if (hi_we !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL mthi_flush: got hi_we=%b stall=%b, want 0 0", hi_we, stall);
    end
    @(posedge clk); #1;
    flush = 0; op = RSVD;
    @(negedge clk);
    checks++;
    if ({hi_we, lo_we, stall} !== 3'b0) begin
      errors++;
      $display("FAIL reserved_op: got we=%b%b stall=%b, want 000", hi_we, lo_we, stall);
    end
    @(posedge clk); #1;
    start = 0; op = NOP;
  endtask

  task automatic test_back_to_back;
    int writes = 0, wc = -1;
    logic [63:0] e;
    sb.push_back(model(DIV, 32'd1000, 32'hFFFF_FFF9));
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); #1;
      start = (c == 0 || c == 5);
      op = (c == 5) ? MTHI : DIV;
      rs = (c == 5) ? 32'hDEAD_BEEF : 32'd1000;
      rt = 32'hFFFF_FFF9;
      @(negedge clk);
      if (hi_we || lo_we) begin
        writes++;
        wc = c;
        e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
        checks++;
        if ({hi_i, lo_i} !== e) begin
          errors++;
          $display("FAIL b2b data: got %h%h, want %h", hi_i, lo_i, e);
        end
      end
    end
    start = 0;
    checks++;
    if (writes != 1 || wc != 33) begin
      errors++;
      $display("FAIL b2b writes: got %0d at c%0d, want 1 at c33", writes, wc);
    end
  endtask

  task automatic test_flush;
    int writes = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      start = (c == 0); op = DIVU; rs = 32'd500; rt = 32'd3;
      flush = (c == 10);
      @(negedge clk);
      if (hi_we || lo_we) writes++;
      if (c == 9) begin
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL flush pre: got stall=%b, want 1", stall); end
      end
      if (c == 10) begin
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL flush stall: got stall=%b, want 0", stall); end
      end
      if (c == 11) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush idle: got busy=%b, want 0", busy); end
      end
    end
    checks++;
    if (writes != 0) begin errors++; $display("FAIL flush writes: got %0d, want 0", writes); end
    for (int c = 0; c < 35; c++) begin
      @(posedge clk); #1;
      start = (c == 0); op = MULTU; rs = 32'd5; rt = 32'd6;
      flush = (c == 33);
      @(negedge clk);
      if (c == 32) begin
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL done_flush pre: got stall=%b, want 1", stall); end
      end
      if (c == 33) begin
        checks++;
        if (hi_we !== 1'b0 || lo_we !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL done_flush: got we=%b%b busy=%b, want 00 1", hi_we, lo_we, busy);
        end
      end
      if (c == 34) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL done_flush idle: got busy=%b, want 0", busy); end
      end
    end
    flush = 0; start = 0;
  endtask

  task automatic test_async_reset;
    @(posedge clk); #1;
    start = 1; op = MULT; rs = 32'd5; rt = 32'd7;
    @(posedge clk); #1;
    start = 0;
    repeat (5) @(posedge clk);
    #3 rst = 1;
    #1;
    checks++;
    if ({stall, busy, hi_we, lo_we} !== 4'b0) begin
      errors++;
      $display("FAIL async_reset: got stall=%b busy=%b we=%b%b, want 0000", stall, busy, hi_we, lo_we);
    end
    @(posedge clk); #1; rst = 0;
    do_op(MULT, 32'd3, 32'd4, {32'd0, 32'd12});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset;
    test_mul;
    test_div;
    test_move;
    test_back_to_back;
    test_flush;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hilo_mdu_ctrl.md
Name: hilo_mdu_ctrl

Overview:
- Multi-cycle multiply/divide sequencer that owns every write into the HI/LO register pair inside the register file.
- Accepts one op per issue from the execute stage: MULT, MULTU, DIV, DIVU, MTHI or MTLO.
- Runs the iterative shift-add multiply or the restoring divide, stalls the pipeline while busy, then emits one write pulse with the 64-bit result.
- Sits between the EX stage and the regfile's hi_we/lo_we/hi_i/lo_i inputs.

Parameters:
- DATA_W, 32, operand width; only 32 is supported.
- MUL_FAST, 0: 1 = multiply completes in 1 BUSY cycle using the `*` operator; 0 = 32-cycle shift-add.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  EX-stage op valid; sampled only in IDLE.
- op  in  3  operation code (see Decomposition).
- rs  in  32  operand A / dividend / MTHI-MTLO source.
- rt  in  32  operand B / divisor.
- flush  in  1  pipeline flush (exception); aborts any op in progress.
- stall  out  1  hold the pipeline at EX.
- busy  out  1  FSM is not in IDLE.
- hi_we  out  1  HI write enable to regfile.
- lo_we  out  1  LO write enable to regfile.
- hi_i  out  32  HI write data.
- lo_i  out  32  LO write data.

Behaviour:
- Reset (asynchronous): state=IDLE, count=0, all internal registers=0, busy=0.
- Outputs under reset: stall=0, hi_we=0, lo_we=0, hi_i=0, lo_i=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE, start=1, op in {MULT, MULTU, DIV, DIVU}, flush=0:
  - Latch rs/rt magnitudes and sign flags; count=0.
  - Go to BUSY next edge.
  - stall=1 combinationally in this same cycle.
- IDLE, start=1, op=MTHI: hi_we=1 and hi_i=rs combinationally in the same cycle; lo_we=0; no stall; stay IDLE.
- IDLE, start=1, op=MTLO: lo_we=1 and lo_i=rs combinationally in the same cycle; hi_we=0; no stall; stay IDLE.
- IDLE, op=NOP or reserved: no action.
- BUSY:
  - One iteration per cycle; count increments.
  - After iteration 32 (count==31 at the edge) go to DONE.
  - With MUL_FAST=1, multiply goes to DONE after 1 BUSY cycle; divide is always 32 cycles.
  - stall=1 throughout; start is ignored.
- DONE (one cycle):
  - hi_we=lo_we=1; hi_i/lo_i driven from result registers.
  - stall=0, so the issuing instruction advances.
  - Return to IDLE next edge.
- Latency: issue cycle c0, BUSY c1..c32, DONE c33. stall is high c0..c32 (33 cycles). Write pulse is at c33.
- Multiply: 64-bit product {hi,lo}. MULT is signed (magnitude product, negated if signs differ). MULTU is unsigned.
- Divide: lo = quotient, hi = remainder. Signed quotient is negated if the signs differ; the remainder takes the dividend's sign.
- Divide by zero, either signedness: lo=32'hFFFF_FFFF, hi=rs. No trap.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0.
- flush=1 in any state:
  - Go to IDLE next edge with no write pulse. The DONE write is suppressed if flush coincides with DONE.
  - In IDLE, flush masks start: no MTHI/MTLO write and no stall.
- stall is never asserted while flush=1.
- Exactly one of {MTHI/MTLO write, DONE write} can occur in a given cycle; they cannot collide because start is ignored outside IDLE.
- busy = (state != IDLE).

Decomposition:
- defines.vh gets these constants:
  - MDU op codes: NOP=3'b000, MULT=3'b001, MULTU=3'b010, DIV=3'b011, DIVU=3'b100, MTHI=3'b101, MTLO=3'b110, 3'b111 reserved (treated as NOP).
  - State encodings: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - MDU_ITER=32.
- One sub-module, mdu_iter_core, holds the unsigned 64-bit shift-add / restoring-divide datapath: one step per enable, with a load input. The FSM, sign handling and write logic stay in hilo_mdu_ctrl.

Test Plan:
- MULT rs=32'hFFFF_FFFE (-2), rt=3: stall high for 33 cycles; in c33 hi_we=lo_we=1, hi_i=32'hFFFF_FFFF, lo_i=32'hFFFF_FFFA.
- MULTU rs=32'hFFFF_FFFF, rt=32'hFFFF_FFFF: write in c33 with hi_i=32'hFFFF_FFFE, lo_i=32'h0000_0001.
- DIV rs=-7 (32'hFFFF_FFF9), rt=2: lo_i=32'hFFFF_FFFD (-3), hi_i=32'hFFFF_FFFF (-1). Then DIVU rs=100, rt=0: lo_i=32'hFFFF_FFFF, hi_i=100.
- MTHI rs=32'h1234_5678 in IDLE: same-cycle hi_we=1, hi_i=32'h1234_5678, lo_we=0, stall=0. A second start during BUSY of a DIV is ignored: exactly one write, at c33.
- Flush: DIVU issued, flush=1 at c10 → IDLE at c11, no write pulse ever, stall=0 from c10. flush asserted in the DONE cycle → hi_we=lo_we=0.
- Async reset: rst asserted mid-BUSY between clock edges → stall/busy/hi_we/lo_we go to 0 immediately. After release, a fresh MULT 3×4 writes lo_i=12, hi_i=0.
